concat_frame_serializer: RTL and testbench
==========================================

Name: concat_frame_serializer

Overview:
Reads one concatenated complex frame `{im, re}` back out of frame RAM and streams it as one complex sample per handshake, sample 0 first. It is the read-side counterpart of the sliding-window concatenation stage. It sits between the frame RAM read port and the FFT input. It marks the first and last sample of each frame, and supports downstream backpressure.

Parameters:
- NP, 1024, samples per frame.
- NB_SAMPLE, 16, bits per real or imaginary sample (signed, 2 integer bits).
- NB_FRAME, 2*NP*NB_SAMPLE, total width of the packed input frame.

Ports:
- clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  global enable; when low the block freezes.
- i_frame  in  NB_FRAME  packed frame. Real sample k is at `[k*NB_SAMPLE +: NB_SAMPLE]`. Imaginary sample k is at `[NP*NB_SAMPLE + k*NB_SAMPLE +: NB_SAMPLE]`.
- i_valid_frame  in  1  i_frame is valid; must be held with stable data until accepted.
- o_ready_frame  out  1  block accepts i_frame this cycle.
- o_x_re  out  NB_SAMPLE  signed real output sample.
- o_x_im  out  NB_SAMPLE  signed imaginary output sample.
- o_valid  out  1  output sample is valid.
- i_ready  in  1  downstream accepts the sample.
- o_sof  out  1  o_valid sample is index 0.
- o_eof  out  1  o_valid sample is index NP-1.

Behaviour:
- Reset (async, active-high): state=IDLE, counter=0, frame register=0, o_valid=0, o_sof=0, o_eof=0, o_x_re=0, o_x_im=0.
  - o_ready_frame=0 while i_reset is high.
  - Reset mid-frame discards the remaining samples; no partial frame resumes.
- State IDLE:
  - o_ready_frame=1 (when i_enable=1), o_valid=0.
  - On `i_valid_frame & o_ready_frame` the frame register captures i_frame, counter=0, and the next state is STREAM.
- State STREAM:
  - o_valid=1.
  - o_x_re/o_x_im are the real/imaginary slice `[counter]` of the frame register, selected combinationally from registered state.
  - o_sof = (counter==0); o_eof = (counter==NP-1).
- Beat: `o_valid & i_ready`.
  - On a beat with counter<NP-1, counter increments.
  - On a beat with counter==NP-1 (last beat):
    - If `i_valid_frame` is also high, capture the new frame, counter=0, remain in STREAM. The result is back-to-back frames with zero bubble.
    - Otherwise go to IDLE, counter=0.
- o_ready_frame rule: `i_enable & (IDLE | (STREAM & counter==NP-1 & i_ready))`.
  - A frame offered at any other time is held off.
  - That frame is not lost; the source keeps i_valid_frame high.
- Backpressure: with i_ready=0 in STREAM, o_x_re/o_x_im/o_sof/o_eof are held stable and o_valid stays 1.
- Latency: frame accepted at edge N; sample 0 is valid in the cycle after edge N. A frame takes exactly NP beats.
- i_enable=0:
  - o_valid=0 and o_ready_frame=0.
  - State, counter and frame register are held.
  - Streaming resumes at the same index when i_enable returns to 1.
- Arithmetic: no scaling. Samples pass bit-exact; the sign is preserved.
- Counter width: `$clog2(NP)`. The counter never wraps without a last beat.

Decomposition:
- Shared package (used by the write-side concatenation stage as well):
  - NP, NB_SAMPLE, NBF_SAMPLE;
  - the frame-width function `2*NP*NB_SAMPLE`;
  - a `sample_offset(k)` constant function defining the frame layout.
- One sub-module: frame_sample_mux. It takes the half-frame and an index and returns one NB_SAMPLE slice; it is instantiated twice (re, im).
- FSM and counter live in the top module.

Test Plan:
All scenarios use NP=8, NB_SAMPLE=16, with re[k]=k+1 and im[k]=-(k+1).
1. Single frame, i_ready=1 constantly. Expected:
   - o_valid for exactly 8 cycles starting the cycle after acceptance;
   - o_x_re=1..8, o_x_im=-1..-8;
   - o_sof on beat 0 only, o_eof on beat 7 only;
   - then o_valid=0 and o_ready_frame=1.
2. Two frames offered back-to-back (second frame re[k]=0x10+k). Expected:
   - second frame accepted on the last beat of the first;
   - 16 consecutive valid beats with no bubble;
   - o_sof at beats 0 and 8.
3. Backpressure: i_ready=0 during beats 3..5. Expected:
   - o_x_re holds 4 with o_valid=1;
   - no sample skipped or duplicated;
   - total beats = 8.
4. Frame offered mid-stream at beat 2. Expected:
   - o_ready_frame=0 until the last beat;
   - the new frame is captured then, and its data starts the next cycle.
5. i_reset asserted asynchronously at beat 4 (between edges). Expected:
   - all outputs 0 immediately;
   - after release the block is in IDLE and the next frame starts at index 0 with re=1.
6. i_enable=0 for 3 cycles at beat 5. Expected:
   - o_valid=0 during those cycles;
   - resumes with o_x_re=6;
   - exactly 8 beats total.

Source files
------------

// File: rtl/concat_frame_serializer_pkg.sv
// Shared frame geometry for the concatenation stage and its read-side serializer.
// Both sides use this package, so they agree on the packed {im, re} frame layout.
package concat_frame_serializer_pkg;

  localparam int NP         = 1024;
  localparam int NB_SAMPLE  = 16;
  localparam int NBF_SAMPLE = NB_SAMPLE - 2;  // two integer bits, rest fractional

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  function automatic int frame_width(input int np, input int nb);
    return 2 * np * nb;
  endfunction

  // Bit offset of sample k within one half-frame (re or im).
  function automatic int sample_offset(input int k, input int nb = NB_SAMPLE);
    return k * nb;
  endfunction

endpackage

// File: rtl/concat_frame_serializer_sample_mux.sv
// Selects one sample out of a packed half-frame (all re or all im samples).
module frame_sample_mux
  import concat_frame_serializer_pkg::*;
#(
    parameter int NP        = concat_frame_serializer_pkg::NP,
    parameter int NB_SAMPLE = concat_frame_serializer_pkg::NB_SAMPLE,
    parameter int NB_INDEX  = (NP > 1) ? $clog2(NP) : 1
) (
    input  logic [NP*NB_SAMPLE-1:0] half,
    input  logic [NB_INDEX-1:0]     index,
    output logic [NB_SAMPLE-1:0]    sample
);

    assign sample = half[sample_offset(int'(index), NB_SAMPLE) +: NB_SAMPLE];

endmodule

// File: rtl/concat_frame_serializer.sv
// Streams one registered {im, re} frame out as NP complex samples, sample 0 first,
// with sof/eof markers, downstream backpressure and zero-bubble frame chaining.
module concat_frame_serializer
  import concat_frame_serializer_pkg::*;
#(
    parameter int NP        = concat_frame_serializer_pkg::NP,
    parameter int NB_SAMPLE = concat_frame_serializer_pkg::NB_SAMPLE,
    parameter int NB_FRAME  = frame_width(NP, NB_SAMPLE)
) (
    input  logic                 clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic [NB_FRAME-1:0]  i_frame,
    input  logic                 i_valid_frame,
    output logic                 o_ready_frame,
    output logic [NB_SAMPLE-1:0] o_x_re,
    output logic [NB_SAMPLE-1:0] o_x_im,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_sof,
    output logic                 o_eof
);

    localparam int CW   = (NP > 1) ? $clog2(NP) : 1;
    localparam int HALF = NP * NB_SAMPLE;

    state_t              state, state_next;
    logic [CW-1:0]       count, count_next;
    logic [NB_FRAME-1:0] frame_q, frame_next;
    logic                last, beat, load;

    // NOTE: the frame register is a plain register, not a RAM, so it takes the async reset
    // like the rest of the state; every sequential assignment is non-blocking.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            state   <= IDLE;
            count   <= '0;
            frame_q <= '0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            frame_q <= frame_next;
        end
    end

    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        state_next = state;
        count_next = count;
        frame_next = frame_q;
        if (load) begin
            frame_next = i_frame;
            count_next = '0;
            state_next = STREAM;
        end else if (beat) begin
            if (last) begin
                count_next = '0;
                state_next = IDLE;
            end else begin
                count_next = count + 1'b1;
            end
        end
    end

    always_comb begin
        last          = (count == CW'(NP - 1));
        o_valid       = i_enable & (state == STREAM);
        beat          = o_valid & i_ready;
        // A new frame is only taken in IDLE or on the final beat, which is what chains frames.
        o_ready_frame = i_enable & ~i_reset &
                        ((state == IDLE) | ((state == STREAM) & last & i_ready));
        load          = i_valid_frame & o_ready_frame;
        o_sof         = o_valid & (count == '0);
        o_eof         = o_valid & last;
    end

    frame_sample_mux #(
        .NP        (NP),
        .NB_SAMPLE (NB_SAMPLE),
        .NB_INDEX  (CW)
    ) u_mux_re (
        .half   (frame_q[HALF-1:0]),
        .index  (count),
        .sample (o_x_re)
    );

    frame_sample_mux #(
        .NP        (NP),
        .NB_SAMPLE (NB_SAMPLE),
        .NB_INDEX  (CW)
    ) u_mux_im (
        .half   (frame_q[NB_FRAME-1:HALF]),
        .index  (count),
        .sample (o_x_im)
    );

endmodule

// File: tb/tb_concat_frame_serializer.sv
// Directed bench for concat_frame_serializer with NP=8: a vector table for a single frame
// plus hand-written sequences for chaining, backpressure, mid-stream offer, reset and enable.
module tb_concat_frame_serializer;

    localparam int NP  = 8;
    localparam int NB  = 16;
    localparam int NBF = 2 * NP * NB;

    logic           clock = 1'b0;
    logic           i_reset;
    logic           i_enable;
    logic [NBF-1:0] i_frame;
    logic           i_valid_frame;
    logic           o_ready_frame;
    logic [NB-1:0]  o_x_re;
    logic [NB-1:0]  o_x_im;
    logic           o_valid;
    logic           i_ready;
    logic           o_sof;
    logic           o_eof;

    int tests  = 0;
    int errors = 0;

    concat_frame_serializer #(
        .NP        (NP),
        .NB_SAMPLE (NB),
        .NB_FRAME  (NBF)
    ) dut (
        .clock         (clock),
        .i_reset       (i_reset),
        .i_enable      (i_enable),
        .i_frame       (i_frame),
        .i_valid_frame (i_valid_frame),
        .o_ready_frame (o_ready_frame),
        .o_x_re        (o_x_re),
        .o_x_im        (o_x_im),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_sof         (o_sof),
        .o_eof         (o_eof)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          en;
        logic          vf;
        logic          rdy;
        logic          exp_valid;
        logic          exp_rf;
        logic [NB-1:0] exp_re;
        logic [NB-1:0] exp_im;
        logic          exp_sof;
        logic          exp_eof;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [NBF-1:0] make_frame(input int base);
        logic [NBF-1:0] f;
        f = '0;
        for (int k = 0; k < NP; k++) begin
            f[k*NB +: NB]         = NB'(base + k);
            f[NP*NB + k*NB +: NB] = NB'(-(base + k));
        end
        return f;
    endfunction

    function automatic logic [NB-1:0] neg(input int v);
        return NB'(-v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are compared 1 ns later.
    task automatic drive(input logic en, input logic vf, input logic rdy, input logic [NBF-1:0] f);
        @(negedge clock);
        i_enable      = en;
        i_valid_frame = vf;
        i_ready       = rdy;
        i_frame       = f;
        #1;
    endtask

    task automatic check_beat(input string tag, input int base, input int k, input logic exp_rf);
        check({tag, " valid"}, 32'(o_valid), 32'(1));
        check({tag, " re"},    32'(o_x_re),  32'(NB'(base + k)));
        check({tag, " im"},    32'(o_x_im),  32'(neg(base + k)));
        check({tag, " sof"},   32'(o_sof),   32'(k == 0));
        check({tag, " eof"},   32'(o_eof),   32'(k == NP - 1));
        check({tag, " rdy_fr"}, 32'(o_ready_frame), 32'(exp_rf));
    endtask

    logic [NBF-1:0] frame_a, frame_b;
    int             beats;

    initial begin
        frame_a = make_frame(1);
        frame_b = make_frame(16);

        // Single-frame vector table.
        vecs[0] = '{en: 1'b1, vf: 1'b1, rdy: 1'b1, exp_valid: 1'b0, exp_rf: 1'b1,
                    exp_re: '0, exp_im: '0, exp_sof: 1'b0, exp_eof: 1'b0};
        for (int k = 0; k < NP; k++)
            vecs[k+1] = '{en: 1'b1, vf: 1'b0, rdy: 1'b1, exp_valid: 1'b1,
                          exp_rf: (k == NP - 1), exp_re: NB'(k + 1), exp_im: neg(k + 1),
                          exp_sof: (k == 0), exp_eof: (k == NP - 1)};
        vecs[9] = '{en: 1'b1, vf: 1'b0, rdy: 1'b1, exp_valid: 1'b0, exp_rf: 1'b1,
                    exp_re: '0, exp_im: '0, exp_sof: 1'b0, exp_eof: 1'b0};

        i_reset = 1'b1; i_enable = 1'b1; i_valid_frame = 1'b0; i_ready = 1'b1; i_frame = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset valid",  32'(o_valid),       32'(0));
        check("reset rdy_fr", 32'(o_ready_frame), 32'(0));
        check("reset re",     32'(o_x_re),        32'(0));
        check("reset im",     32'(o_x_im),        32'(0));
        check("reset sof",    32'(o_sof),         32'(0));
        check("reset eof",    32'(o_eof),         32'(0));
        @(negedge clock);
        i_reset = 1'b0;

        // 1: single frame, table driven.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].en, vecs[i].vf, vecs[i].rdy, vecs[i].vf ? frame_a : '0);
            check($sformatf("t1[%0d] valid", i),  32'(o_valid),       32'(vecs[i].exp_valid));
            check($sformatf("t1[%0d] rdy_fr", i), 32'(o_ready_frame), 32'(vecs[i].exp_rf));
            check($sformatf("t1[%0d] sof", i),    32'(o_sof),         32'(vecs[i].exp_sof));
            check($sformatf("t1[%0d] eof", i),    32'(o_eof),         32'(vecs[i].exp_eof));
            if (vecs[i].exp_valid) begin
                check($sformatf("t1[%0d] re", i), 32'(o_x_re), 32'(vecs[i].exp_re));
                check($sformatf("t1[%0d] im", i), 32'(o_x_im), 32'(vecs[i].exp_im));
            end
        end

        // 2: back-to-back frames, B offered throughout A.
        drive(1'b1, 1'b1, 1'b1, frame_a);
        check("t2 accept A", 32'(o_ready_frame), 32'(1));
        for (int b = 0; b < 2 * NP; b++) begin
            drive(1'b1, b < NP, 1'b1, (b < NP) ? frame_b : '0);
            check_beat($sformatf("t2[%0d]", b), (b < NP) ? 1 : 16, b % NP, (b % NP) == NP - 1);
        end
        drive(1'b1, 1'b0, 1'b1, '0);
        check("t2 idle valid", 32'(o_valid), 32'(0));

        // 3: backpressure at index 3 for three cycles.
        drive(1'b1, 1'b1, 1'b1, frame_a);
        beats = 0;
        for (int c = 0, k = 0; c < NP + 3; c++) begin
            logic rdy;
            rdy = !(c >= 3 && c < 6);
            drive(1'b1, 1'b0, rdy, '0);
            if (!rdy) begin
                check($sformatf("t3 stall%0d valid", c), 32'(o_valid), 32'(1));
                check($sformatf("t3 stall%0d re", c),    32'(o_x_re),  32'(4));
                check($sformatf("t3 stall%0d sof", c),   32'(o_sof),   32'(0));
            end else begin
                check_beat($sformatf("t3[%0d]", k), 1, k, k == NP - 1);
                k++;
            end
            if (o_valid && i_ready) beats++;
        end
        drive(1'b1, 1'b0, 1'b1, '0);
        check("t3 done valid", 32'(o_valid), 32'(0));
        check("t3 beats", 32'(beats), 32'(NP));

        // 4: frame B offered from beat 2 is held off until A's last beat.
        drive(1'b1, 1'b1, 1'b1, frame_a);
        for (int k = 0; k < NP; k++) begin
            drive(1'b1, k >= 2, 1'b1, (k >= 2) ? frame_b : '0);
            check_beat($sformatf("t4a[%0d]", k), 1, k, k == NP - 1);
        end
        for (int k = 0; k < NP; k++) begin
            drive(1'b1, 1'b0, 1'b1, '0);
            check_beat($sformatf("t4b[%0d]", k), 16, k, k == NP - 1);
        end

        // 5: async reset between edges at beat 4.
        drive(1'b1, 1'b1, 1'b1, frame_a);
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 1'b1, '0);
        drive(1'b1, 1'b0, 1'b1, '0);
        check("t5 pre re", 32'(o_x_re), 32'(5));
        i_reset = 1'b1;
        #1;
        check("t5 rst valid",  32'(o_valid),       32'(0));
        check("t5 rst re",     32'(o_x_re),        32'(0));
        check("t5 rst im",     32'(o_x_im),        32'(0));
        check("t5 rst sof",    32'(o_sof),         32'(0));
        check("t5 rst eof",    32'(o_eof),         32'(0));
        check("t5 rst rdy_fr", 32'(o_ready_frame), 32'(0));
        @(negedge clock);
        i_reset = 1'b0;
        drive(1'b1, 1'b0, 1'b1, '0);
        check("t5 idle valid",  32'(o_valid),       32'(0));
        check("t5 idle rdy_fr", 32'(o_ready_frame), 32'(1));
        drive(1'b1, 1'b1, 1'b1, frame_a);
        for (int k = 0; k < NP; k++) begin
            drive(1'b1, 1'b0, 1'b1, '0);
            check_beat($sformatf("t5[%0d]", k), 1, k, k == NP - 1);
        end

        // 6: enable low for three cycles at beat 5.
        drive(1'b1, 1'b1, 1'b1, frame_a);
        beats = 0;
        for (int c = 0, k = 0; c < NP + 3; c++) begin
            logic en;
            en = !(c >= 5 && c < 8);
            drive(en, 1'b0, 1'b1, '0);
            if (!en) begin
                check($sformatf("t6 off%0d valid", c),  32'(o_valid),       32'(0));
                check($sformatf("t6 off%0d rdy_fr", c), 32'(o_ready_frame), 32'(0));
            end else begin
                check_beat($sformatf("t6[%0d]", k), 1, k, k == NP - 1);
                k++;
            end
            if (o_valid && i_ready) beats++;
        end
        drive(1'b1, 1'b0, 1'b1, '0);
        check("t6 done valid", 32'(o_valid), 32'(0));
        check("t6 beats", 32'(beats), 32'(NP));

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
